// File: rtl/pipe_ctrl_sched_if.sv
// Pipeline sequencer bus: hazard/halt requests in, stage controls and debug/perf out.
// master = core side driving requests, slave = the sequencer.
interface pipe_ctrl_sched_if #(
  parameter int CNT_W = 16
);
  logic             raw_stall;
  logic             ctrl_haz;
  logic             mem_busy;
  logic             halt_dec;
  logic             en_pc;
  logic             en_idex;
  logic             en_exmem;
  logic             en_memwb;
  logic             bubble_ex;
  logic             flush_if;
  logic             flush_id;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output raw_stall, ctrl_haz, mem_busy, halt_dec,
    input  en_pc, en_idex, en_exmem, en_memwb, bubble_ex, flush_if, flush_id,
           halted, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  raw_stall, ctrl_haz, mem_busy, halt_dec,
    output en_pc, en_idex, en_exmem, en_memwb, bubble_ex, flush_if, flush_id,
           halted, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_sched.sv
// Central 5-stage pipeline sequencer: merges mem_busy > ctrl_haz > raw_stall > halt_dec
// into latch enables, bubble and flush controls; owns flush windows and drain-before-halt.
// Optional stall/flush performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_sched #(
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    FLUSH   = 3'd1,
    MEMWAIT = 3'd2,
    DRAIN   = 3'd3,
    HALTED  = 3'd4
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_RELOAD = 3'(DRAIN_CYCLES);

  state_t     state_q, state_d, saved_q, saved_d, eff_state;
  logic [2:0] rem_q, rem_d;
  logic       pend_q, pend_d;
  logic       exiting, haz;
  logic       en_pc, en_rest, bubble_ex, flush, halted;

  // On the first idle-memory cycle in MEMWAIT the saved state is evaluated directly,
  // so the restored state's outputs appear with no lost cycle; a recorded ctrl_haz joins in.
  assign exiting   = (state_q == MEMWAIT) && !bus.mem_busy;
  assign eff_state = exiting ? saved_q : state_q;
  assign haz       = bus.ctrl_haz || (exiting && pend_q);

  // Next-state and Mealy output decode
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    rem_d     = rem_q;
    pend_d    = pend_q;
    en_pc     = 1'b0;
    en_rest   = 1'b0;
    bubble_ex = 1'b0;
    flush     = 1'b0;
    halted    = 1'b0;
    if (rst) begin
      case (eff_state)
        HALTED: halted = 1'b1;
        MEMWAIT: pend_d = pend_q || bus.ctrl_haz;
        default: begin
          if (bus.mem_busy) begin
            state_d = MEMWAIT;
            saved_d = eff_state;
            pend_d  = bus.ctrl_haz;
          end else begin
            pend_d  = 1'b0;
            en_rest = 1'b1;
            if (haz) begin
              en_pc   = 1'b1;
              flush   = 1'b1;
              state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
              rem_d   = FLUSH_RELOAD;
            end else if (eff_state == FLUSH) begin
              en_pc   = 1'b1;
              flush   = 1'b1;
              rem_d   = rem_q - 3'd1;
              state_d = (rem_q == 3'd1) ? RUN : FLUSH;
            end else if (eff_state == DRAIN) begin
              bubble_ex = 1'b1;
              rem_d     = rem_q - 3'd1;
              state_d   = (rem_q == 3'd1) ? HALTED : DRAIN;
            end else begin
              state_d = RUN;
              if (bus.raw_stall) begin
                bubble_ex = 1'b1;
              end else if (bus.halt_dec) begin
                bubble_ex = 1'b1;
                state_d   = DRAIN;
                rem_d     = DRAIN_RELOAD;
              end else begin
                en_pc = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  // FSM state, remaining-cycle count, saved state and recorded hazard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      saved_q <= RUN;
      rem_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.en_pc     = en_pc;
  assign bus.en_idex   = en_rest;
  assign bus.en_exmem  = en_rest;
  assign bus.en_memwb  = en_rest;
  assign bus.bubble_ex = bubble_ex && !flush;
  assign bus.flush_if  = flush;
  assign bus.flush_id  = flush;
  assign bus.halted    = halted;
  assign bus.state     = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;

  assign stall_inc = (eff_state != HALTED) &&
                     (bus.mem_busy || (eff_state == RUN && bus.raw_stall && !haz));
  assign flush_inc = (eff_state != HALTED) && !bus.mem_busy && haz;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_sched.sv
// Directed bench for pipe_ctrl_sched (FLUSH_CYCLES=2, DRAIN_CYCLES=3).
// Output vector: {en_pc,en_idex,en_exmem,en_memwb,bubble_ex,flush_if,flush_id,halted}.
module tb_pipe_ctrl_sched;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [7:0] O_RUN   = 8'hF0;
  localparam logic [7:0] O_STALL = 8'h78;
  localparam logic [7:0] O_FLUSH = 8'hF6;
  localparam logic [7:0] O_ZERO  = 8'h00;
  localparam logic [7:0] O_HALT  = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_ctrl_sched_if #(.CNT_W(16)) bus ();

  pipe_ctrl_sched #(
    .FLUSH_CYCLES(2),
    .DRAIN_CYCLES(3),
    .CNT_W       (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.en_pc, bus.en_idex, bus.en_exmem, bus.en_memwb,
                bus.bubble_ex, bus.flush_if, bus.flush_id, bus.halted});
  endfunction

  task automatic drive(input logic rs, input logic ch, input logic mb, input logic hd);
    bus.raw_stall = rs;
    bus.ctrl_haz  = ch;
    bus.mem_busy  = mb;
    bus.halt_dec  = hd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check combinational outputs and registered state in the current cycle, then advance
  task automatic cyc(input string tag, input logic [7:0] eo, input logic [2:0] es);
    check({tag, ".outs"}, outs(), 32'(eo));
    check({tag, ".state"}, 32'(bus.state), 32'(es));
    tick();
  endtask

  task automatic counters(input string tag, input int es, input int ef);
    check({tag, ".stall_cnt"}, 32'(bus.stall_cnt), PERF ? 32'(es) : 32'd0);
    check({tag, ".flush_cnt"}, 32'(bus.flush_cnt), PERF ? 32'(ef) : 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // 1: reset values while held low, then idle RUN
    bus.raw_stall = 0; bus.ctrl_haz = 0; bus.mem_busy = 0; bus.halt_dec = 0;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      check("t1.rst_outs", outs(), 32'(O_ZERO));
      check("t1.rst_state", 32'(bus.state), 32'd0);
      tick();
    end
    counters("t1.rst", 0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    cyc("t1.idle", O_RUN, 3'd0);
    counters("t1.idle", 0, 0);

    // 2: raw_stall two cycles
    drive(1, 0, 0, 0); cyc("t2.s0", O_STALL, 3'd0);
    drive(1, 0, 0, 0); cyc("t2.s1", O_STALL, 3'd0);
    drive(0, 0, 0, 0);
    counters("t2", 2, 0);
    cyc("t2.idle", O_RUN, 3'd0);

    // 3: ctrl_haz with raw_stall held: two flush cycles, stall then resumes
    do_reset();
    drive(1, 1, 0, 0); cyc("t3.detect", O_FLUSH, 3'd0);
    drive(1, 0, 0, 0); cyc("t3.flush2", O_FLUSH, 3'd1);
    drive(1, 0, 0, 0); cyc("t3.resume", O_STALL, 3'd0);
    drive(0, 0, 0, 0);
    counters("t3", 1, 1);

    // 4: mem_busy for 4 cycles during flush cycle 2, one flush cycle remains after
    do_reset();
    drive(0, 1, 0, 0); cyc("t4.detect", O_FLUSH, 3'd0);
    drive(0, 0, 1, 0); cyc("t4.busy0", O_ZERO, 3'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0); cyc("t4.busyN", O_ZERO, 3'd2);
    end
    drive(0, 0, 0, 0); cyc("t4.restore", O_FLUSH, 3'd2);
    drive(0, 0, 0, 0); cyc("t4.run", O_RUN, 3'd0);
    counters("t4", 4, 1);

    // 4b: ctrl_haz arriving while in MEMWAIT is applied on exit
    do_reset();
    drive(0, 0, 1, 0); cyc("t4b.busy0", O_ZERO, 3'd0);
    drive(0, 1, 1, 0); cyc("t4b.haz_wait", O_ZERO, 3'd2);
    drive(0, 0, 0, 0); cyc("t4b.apply", O_FLUSH, 3'd2);
    drive(0, 0, 0, 0); cyc("t4b.flush2", O_FLUSH, 3'd1);
    drive(0, 0, 0, 0); cyc("t4b.run", O_RUN, 3'd0);
    counters("t4b", 2, 1);

    // 5: halt_dec, three drain cycles, then frozen regardless of inputs
    do_reset();
    drive(0, 0, 0, 1); cyc("t5.decode", O_STALL, 3'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0); cyc("t5.drain", O_STALL, 3'd3);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'(i), 1'(i >> 1), 1'(i == 5), 1'(i == 7));
      cyc("t5.halted", O_HALT, 3'd4);
    end
    counters("t5", 0, 0);
    rst = 1'b0;
    #1;
    check("t5.async_rst_outs", outs(), 32'(O_ZERO));
    check("t5.async_rst_state", 32'(bus.state), 32'd0);
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    cyc("t5.after_rst", O_RUN, 3'd0);

    // 6: ctrl_haz in drain cycle 2 cancels the halt
    do_reset();
    drive(0, 0, 0, 1); cyc("t6.decode", O_STALL, 3'd0);
    drive(0, 0, 0, 0); cyc("t6.drain1", O_STALL, 3'd3);
    drive(0, 1, 0, 0); cyc("t6.cancel", O_FLUSH, 3'd3);
    drive(0, 0, 0, 0); cyc("t6.flush2", O_FLUSH, 3'd1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0); cyc("t6.run", O_RUN, 3'd0);
    end
    counters("t6", 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
